// File: rtl/gcm_pkg.sv
// Shared types and helpers for the GCM counter-mode datapath.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents: block/key widths, the GCTR FSM state encoding, and inc_s, the
// counter-block increment over the low w bits (w=32 is the classic GCM Inc).
package gcm_pkg;

  localparam int BLK_W = 64;
  localparam int KEY_W = 80;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_WAIT  = 3'd2,
    ST_READY = 3'd3,
    ST_HOLD  = 3'd4
  } state_e;

  // Increment the low w bits of cb modulo 2^w; the upper BLK_W-w bits pass
  // through untouched. w >= BLK_W degenerates to a full-width increment.
  function automatic logic [BLK_W-1:0] inc_s(input logic [BLK_W-1:0] cb,
                                             input int unsigned       w);
    logic [BLK_W-1:0] m;
    m = (w >= BLK_W) ? '1 : ((BLK_W'(1) << w) - BLK_W'(1));
    return (cb & ~m) | ((cb + BLK_W'(1)) & m);
  endfunction

endpackage

// File: rtl/present80.sv
// Iterative PRESENT-80 block cipher, one round per clock.
// Latency: load sampled at edge L, ciphertext stable from edge L+31 onward.
// Backpressure: none; result holds until the next load.
//
// Ports: clk, reset (sync, active-high), load (start new encryption),
//        indata[63:0] plaintext, key[79:0] cipher key, outdata[63:0] ciphertext.
// The result stays valid indefinitely after completion, so any caller wait of
// 32 or more cycles from the load cycle sees a stable ciphertext.
module present80
  import gcm_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [BLK_W-1:0] indata,
  input  logic [KEY_W-1:0] key,
  output logic [BLK_W-1:0] outdata
);

  logic [BLK_W-1:0] s_q, s_d;
  logic [KEY_W-1:0] k_q, k_d;
  logic [4:0]       rnd_q, rnd_d;
  logic             run_q, run_d;

  function automatic logic [3:0] sbox4(input logic [3:0] x);
    logic [3:0] y;
    y = 4'h0;
    case (x)
      4'h0: y = 4'hC;  4'h1: y = 4'h5;  4'h2: y = 4'h6;  4'h3: y = 4'hB;
      4'h4: y = 4'h9;  4'h5: y = 4'h0;  4'h6: y = 4'hA;  4'h7: y = 4'hD;
      4'h8: y = 4'h3;  4'h9: y = 4'hE;  4'hA: y = 4'hF;  4'hB: y = 4'h8;
      4'hC: y = 4'h4;  4'hD: y = 4'h7;  4'hE: y = 4'h1;  4'hF: y = 4'h2;
      default: y = 4'h0;
    endcase
    return y;
  endfunction

  function automatic logic [BLK_W-1:0] s_layer(input logic [BLK_W-1:0] x);
    logic [BLK_W-1:0] y;
    y = '0;
    for (int j = 0; j < 16; j++) y[4*j +: 4] = sbox4(x[4*j +: 4]);
    return y;
  endfunction

  // Bit i = 4q + r lands at 16r + q (equivalent to i*16 mod 63, bit 63 fixed).
  function automatic logic [BLK_W-1:0] p_layer(input logic [BLK_W-1:0] x);
    logic [BLK_W-1:0] y;
    y = '0;
    for (int i = 0; i < 64; i++) y[16*(i%4) + i/4] = x[i];
    return y;
  endfunction

  function automatic logic [KEY_W-1:0] key_next(input logic [KEY_W-1:0] k,
                                                input logic [4:0]       rc);
    logic [KEY_W-1:0] r;
    r          = {k[18:0], k[79:19]};
    r[79:76]   = sbox4(r[79:76]);
    r[19:15]   = r[19:15] ^ rc;
    return r;
  endfunction

  always_comb begin
    s_d   = s_q;
    k_d   = k_q;
    rnd_d = rnd_q;
    run_d = run_q;
    if (load) begin
      s_d   = indata;
      k_d   = key;
      rnd_d = 5'd1;
      run_d = 1'b1;
    end else if (run_q) begin
      s_d   = p_layer(s_layer(s_q ^ k_q[79:16]));
      k_d   = key_next(k_q, rnd_q);
      rnd_d = rnd_q + 5'd1;
      run_d = (rnd_q != 5'd31);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s_q   <= '0;
      k_q   <= '0;
      rnd_q <= '0;
      run_q <= 1'b0;
    end else begin
      s_q   <= s_d;
      k_q   <= k_d;
      rnd_q <= rnd_d;
      run_q <= run_d;
    end
  end

  // Final whitening with round key 32.
  assign outdata = s_q ^ k_q[79:16];

endmodule

// File: rtl/gctr_stream.sv
// Streaming GCTR: XORs E(K, CB) onto a valid/ready block stream, one message per start.
// Latency: in_ready CIPHER_LAT+2 cycles after start; output registered 1 cycle after input handshake.
// Backpressure: one block in flight; in_ready low until the held output is taken by out_ready.
//
// Ports: clk, reset (sync, active-high); start/icb_in/key_in begin a message;
//        in_valid/in_ready/in_data/in_last/in_bytes input block stream;
//        out_valid/out_ready/out_data/out_last/out_bytes output block stream;
//        busy high whenever a message is in progress.
module gctr_stream
  import gcm_pkg::*;
#(
  parameter logic [63:0] ICB_RST    = 64'hABAC_8CA6_000A_A98A,
  parameter int          INC_W      = 32,
  parameter int          CIPHER_LAT = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [63:0] icb_in,
  input  logic [79:0] key_in,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_data,
  input  logic        in_last,
  input  logic [3:0]  in_bytes,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_data,
  output logic        out_last,
  output logic [3:0]  out_bytes,
  output logic        busy
);

  localparam int LAT_W = (CIPHER_LAT > 1) ? $clog2(CIPHER_LAT) : 1;

  state_e           state_q, state_d;
  logic [BLK_W-1:0] cb_q, cb_d;
  logic [KEY_W-1:0] key_q, key_d;
  logic [LAT_W-1:0] lat_q, lat_d;
  logic [BLK_W-1:0] out_data_q, out_data_d;
  logic             out_last_q, out_last_d;
  logic [3:0]       out_bytes_q, out_bytes_d;

  logic             p80_load;
  logic [BLK_W-1:0] keystream;
  logic [3:0]       n_bytes;

  // Keep the leading n bytes (byte 0 = bits 63:56), zero the rest.
  function automatic logic [BLK_W-1:0] byte_mask(input logic [3:0] n);
    logic [BLK_W-1:0] m;
    m = '0;
    for (int i = 0; i < 8; i++) m[63-8*i -: 8] = (4'(i) < n) ? 8'hFF : 8'h00;
    return m;
  endfunction

  present80 u_present80 (
    .clk     (clk),
    .reset   (reset),
    .load    (p80_load),
    .indata  (cb_q),
    .key     (key_q),
    .outdata (keystream)
  );

  // Non-final blocks are always full; a final count of 0 or >8 means full.
  assign n_bytes = (!in_last || in_bytes == 4'd0 || in_bytes > 4'd8) ? 4'd8 : in_bytes;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start)      state_d = ST_LOAD;
      ST_LOAD:                  state_d = ST_WAIT;
      ST_WAIT:  if (lat_q == '0) state_d = ST_READY;
      ST_READY: if (in_valid)   state_d = ST_HOLD;
      ST_HOLD:  if (out_ready)  state_d = out_last_q ? ST_IDLE : ST_LOAD;
      default:                  state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    in_ready  = (state_q == ST_READY);
    out_valid = (state_q == ST_HOLD);
    busy      = (state_q != ST_IDLE);
    p80_load  = (state_q == ST_LOAD);
  end

  // Datapath next-state. The counter only advances on the output handshake,
  // so a stalled block never skips or repeats a counter value.
  always_comb begin
    cb_d        = cb_q;
    key_d       = key_q;
    lat_d       = lat_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_bytes_d = out_bytes_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          cb_d  = icb_in;
          key_d = key_in;
        end
      end
      ST_LOAD: lat_d = LAT_W'(CIPHER_LAT - 1);
      ST_WAIT: begin
        if (lat_q != '0) lat_d = lat_q - LAT_W'(1);
      end
      ST_READY: begin
        if (in_valid) begin
          out_data_d  = (in_data ^ keystream) & byte_mask(n_bytes);
          out_last_d  = in_last;
          out_bytes_d = n_bytes;
        end
      end
      ST_HOLD: begin
        if (out_ready) cb_d = inc_s(cb_q, INC_W);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cb_q        <= ICB_RST;
      key_q       <= '0;
      lat_q       <= '0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_bytes_q <= '0;
    end else begin
      cb_q        <= cb_d;
      key_q       <= key_d;
      lat_q       <= lat_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_bytes_q <= out_bytes_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign out_bytes = out_bytes_q;

endmodule

// File: tb/tb_gctr_stream.sv
// Directed bench for gctr_stream: reset, PRESENT-80 known answers, counter
// wrap, partial blocks, backpressure, and mid-message start/reset.
module tb_gctr_stream;

  localparam int          LAT     = 32;
  localparam logic [63:0] ICB_RST = 64'hABAC_8CA6_000A_A98A;
  localparam logic [63:0] K00     = 64'h5579C1387B228445;  // E(0, 0)

  localparam logic [3:0] SB [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                                     4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};

  logic        clk, reset, start;
  logic [63:0] icb_in;
  logic [79:0] key_in;
  logic        in_valid, in_ready, in_last;
  logic [63:0] in_data;
  logic [3:0]  in_bytes;
  logic        out_valid, out_ready, out_last;
  logic [63:0] out_data;
  logic [3:0]  out_bytes;
  logic        busy;

  int nvec  = 0;
  int nfail = 0;

  gctr_stream #(.ICB_RST(ICB_RST), .INC_W(32), .CIPHER_LAT(LAT)) dut (
    .clk(clk), .reset(reset), .start(start), .icb_in(icb_in), .key_in(key_in),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .in_bytes(in_bytes),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .out_bytes(out_bytes), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog");
  end

  // Reference PRESENT-80 encryption, straight from the algorithm description.
  function automatic logic [63:0] present_ref(input logic [63:0] pt, input logic [79:0] key);
    logic [63:0] s, t;
    logic [79:0] k;
    s = pt;
    k = key;
    for (int r = 1; r <= 31; r++) begin
      s = s ^ k[79:16];
      for (int j = 0; j < 16; j++) s[4*j +: 4] = SB[s[4*j +: 4]];
      t = '0;
      for (int i = 0; i < 63; i++) t[(i*16) % 63] = s[i];
      t[63] = s[63];
      s = t;
      k = {k[18:0], k[79:19]};
      k[79:76] = SB[k[79:76]];
      k[19:15] = k[19:15] ^ 5'(r);
    end
    return s ^ k[79:16];
  endfunction

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic start_msg(input logic [63:0] icb, input logic [79:0] key);
    icb_in = icb;
    key_in = key;
    start  = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
    // Scramble the message inputs: they must have been latched already.
    icb_in = {$urandom, $urandom};
    key_in = {16'hBEEF, $urandom, $urandom};
  endtask

  task automatic put_block(input logic [63:0] d, input logic l, input logic [3:0] b);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    in_bytes = b;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("in_ready_wait", 80'(in_ready), 80'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("out_valid_after_hs", 80'(out_valid), 80'(1));
    chk("in_ready_in_hold", 80'(in_ready), 80'(0));
  endtask

  task automatic check_out(input string tag, input logic [63:0] d, input logic l,
                           input logic [3:0] b);
    chk({tag, "_data"},  80'(out_data),  80'(d));
    chk({tag, "_last"},  80'(out_last),  80'(l));
    chk({tag, "_bytes"}, 80'(out_bytes), 80'(b));
  endtask

  task automatic take_out();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("out_valid_cleared", 80'(out_valid), 80'(0));
  endtask

  initial begin
    int cyc;
    logic [63:0] icb_w, d_x;
    logic [79:0] key_x;

    // ---- reset with random inputs, start asserted ----
    reset = 1'b1;
    out_ready = 1'b0; in_valid = 1'b0; start = 1'b0;
    in_data = '0; in_last = 1'b0; in_bytes = '0; icb_in = '0; key_in = '0;
    for (int r = 0; r < 3; r++) begin
      start = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
      icb_in = {$urandom, $urandom}; key_in = {16'h1234, $urandom, $urandom};
      in_data = {$urandom, $urandom}; in_last = 1'b1; in_bytes = 4'd3;
      @(posedge clk); #1;
      chk("rst_in_ready",  80'(in_ready),  80'(0));
      chk("rst_out_valid", 80'(out_valid), 80'(0));
      chk("rst_out_data",  80'(out_data),  80'(0));
      chk("rst_out_last",  80'(out_last),  80'(0));
      chk("rst_out_bytes", 80'(out_bytes), 80'(0));
      chk("rst_busy",      80'(busy),      80'(0));
      chk("rst_cb",        80'(dut.cb_q),  80'(ICB_RST));
      chk("rst_key",       dut.key_q,      80'(0));
    end
    reset = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_data = '0; in_last = 1'b0; in_bytes = '0;
    @(posedge clk); #1;
    chk("idle_busy", 80'(busy), 80'(0));

    // ---- single block, key=0, icb=0; in_ready latency ----
    start_msg(64'h0, 80'h0);
    chk("busy_load", 80'(busy), 80'(1));
    cyc = 1;
    while (!in_ready && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("in_ready_latency", 80'(cyc), 80'(LAT + 2));
    put_block(64'h0, 1'b1, 4'd8);
    check_out("single", K00, 1'b1, 4'd8);
    take_out();
    chk("single_busy_end", 80'(busy), 80'(0));
    chk("single_cb_inc", 80'(dut.cb_q), 80'(1));

    // ---- known answers: all-ones key; all-ones counter with low-word wrap ----
    start_msg(64'h0, '1);
    put_block(64'h0, 1'b1, 4'd8);
    check_out("kat_key1", 64'hE72C46C0F5945049, 1'b1, 4'd8);
    take_out();
    start_msg('1, 80'h0);
    put_block(64'h0, 1'b1, 4'd8);
    check_out("kat_pt1", 64'hA112FFC72F68417B, 1'b1, 4'd8);
    take_out();
    chk("wrap_upper_kept", 80'(dut.cb_q), 80'(64'hFFFFFFFF_00000000));

    // ---- counter wrap over two blocks ----
    icb_w = 64'h00000000_FFFFFFFF;
    start_msg(icb_w, 80'h0);
    put_block(64'h0, 1'b0, 4'd8);
    check_out("wrap_b1", present_ref(icb_w, 80'h0), 1'b0, 4'd8);
    take_out();
    chk("wrap_cb", 80'(dut.cb_q), 80'(0));
    put_block(64'h0, 1'b1, 4'd8);
    check_out("wrap_b2", K00, 1'b1, 4'd8);
    take_out();

    // ---- partial final blocks ----
    start_msg(64'h0, 80'h0);
    put_block(64'h0, 1'b1, 4'd3);
    check_out("part3", 64'h5579C100_00000000, 1'b1, 4'd3);
    take_out();
    start_msg(64'h0, 80'h0);
    put_block(64'h0, 1'b1, 4'd0);
    check_out("part0", K00, 1'b1, 4'd8);
    take_out();
    start_msg(64'h0, 80'h0);
    put_block(64'h0123456789ABCDEF, 1'b1, 4'd5);
    check_out("part5", 64'h545A845FF2000000, 1'b1, 4'd5);
    take_out();
    start_msg(64'h0, 80'h0);
    put_block(64'h0, 1'b1, 4'd9);
    check_out("part9", K00, 1'b1, 4'd8);
    take_out();

    // ---- backpressure: 10 stalled cycles, then cb+1 exactly once ----
    start_msg(64'h0, 80'h0);
    put_block(64'h0, 1'b0, 4'd3);
    check_out("bp_b1", K00, 1'b0, 4'd8);
    in_valid = 1'b1;
    in_data  = '1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("bp_data_stable", 80'(out_data),  80'(K00));
      chk("bp_out_valid",   80'(out_valid), 80'(1));
      chk("bp_in_ready",    80'(in_ready),  80'(0));
      chk("bp_cb_held",     80'(dut.cb_q),  80'(0));
    end
    take_out();
    chk("bp_cb_once", 80'(dut.cb_q), 80'(1));
    put_block(64'h0, 1'b1, 4'd8);
    check_out("bp_b2", present_ref(64'h1, 80'h0), 1'b1, 4'd8);
    take_out();
    chk("bp_cb_end", 80'(dut.cb_q), 80'(2));

    // ---- start and out_ready ignored in WAIT, then reset mid-message ----
    start_msg(64'h100, 80'h0);
    repeat (4) begin @(posedge clk); #1; end
    start = 1'b1; icb_in = 64'h0BAD; out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; out_ready = 1'b0;
    chk("wait_start_ign_cb", 80'(dut.cb_q), 80'(64'h100));
    chk("wait_busy",         80'(busy),     80'(1));
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("midrst_busy",     80'(busy),      80'(0));
    chk("midrst_in_ready", 80'(in_ready),  80'(0));
    chk("midrst_cb",       80'(dut.cb_q),  80'(ICB_RST));
    key_x = 80'h0123_4567_89AB_CDEF_0F1E;
    icb_w = 64'hCAFEF00D_12345678;
    d_x   = 64'hFEDCBA98_76543210;
    start_msg(icb_w, key_x);
    put_block(d_x, 1'b1, 4'd8);
    check_out("post_rst", present_ref(icb_w, key_x) ^ d_x, 1'b1, 4'd8);
    take_out();
    chk("post_rst_busy", 80'(busy), 80'(0));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
